svm_scheduler_top: RTL and testbench

//  Top of the SVM transaction scheduler. Accepts one transaction (owner/program ID plus read and write

---
 rtl/svm_scheduler_top.sv | 190 +++++++++++++++++++
 tb/tb_svm_scheduler_top.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/svm_scheduler_top.sv
// SVM transaction scheduler: a hazard filter scan, then lock-table insertion, then a batch/result stage.
// Transactions are processed one at a time, and the lock table is cleared when a batch of accepts fills.
module svm_scheduler_top #(
  parameter int MAX_TRANSACTIONS     = 48,
  parameter int DEPS_PER_TRANSACTION = 1024,
  parameter int LOCK_ENTRIES         = 256
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [63:0]                        owner_programID,
  input  logic [DEPS_PER_TRANSACTION*64-1:0] read_dependencies,
  input  logic [DEPS_PER_TRANSACTION*64-1:0] write_dependencies,
  input  logic                               transaction_valid,
  output logic                               transaction_accepted,
  output logic [63:0]                        inserted_programID,
  output logic                               has_conflict,
  output logic [63:0]                        conflicting_id
);
  localparam int DATA_W = 64;
  localparam int VEC_W  = DEPS_PER_TRANSACTION * DATA_W;
  localparam int IDX_W  = (DEPS_PER_TRANSACTION > 1) ? $clog2(DEPS_PER_TRANSACTION) : 1;
  localparam int ENT_W  = (LOCK_ENTRIES > 1) ? $clog2(LOCK_ENTRIES) : 1;
  localparam int CW     = $clog2(2 * DEPS_PER_TRANSACTION + LOCK_ENTRIES + 1) + 1;
  localparam int BW     = $clog2(MAX_TRANSACTIONS + 1);

  typedef enum logic [2:0] {S_IDLE, S_FILTER, S_INSERT, S_DONE, S_REJECT} state_t;
  state_t state, state_nxt;

  logic [DATA_W-1:0] owner_id_p0;
  logic [VEC_W-1:0]  rd_vec_p0, wr_vec_p0;
  logic [IDX_W-1:0]  idx_p1;
  logic [CW-1:0]     nz_cnt_p1, used_cnt;
  logic [BW-1:0]     batch_cnt;
  logic              batch_full;

  logic              lk_valid [LOCK_ENTRIES];
  logic [DATA_W-1:0] lk_addr  [LOCK_ENTRIES];
  logic              lk_wr    [LOCK_ENTRIES];
  logic [DATA_W-1:0] lk_owner [LOCK_ENTRIES];

  logic [DATA_W-1:0] rd_addr, wr_addr, reject_id;
  logic              rd_nz, wr_nz, last, overflow, rd_hit_any, wr_hit_any;
  logic              filter_ready, insertion_ready;
  logic [ENT_W-1:0]  rd_ent, wr_ent, f0, f1, wr_slot;
  logic              f0_ok, f1_ok;
  logic [CW-1:0]     nz_total;

  // Filter stage: compare the current read/write slot against every valid lock entry.
  always_comb begin
    rd_addr    = rd_vec_p0[idx_p1*DATA_W +: DATA_W];
    wr_addr    = wr_vec_p0[idx_p1*DATA_W +: DATA_W];
    rd_nz      = |rd_addr;
    wr_nz      = |wr_addr;
    rd_hit_any = 1'b0;
    wr_hit_any = 1'b0;
    rd_ent     = '0;
    wr_ent     = '0;
    for (int e = LOCK_ENTRIES - 1; e >= 0; e--) begin
      if (lk_valid[e] && rd_nz && lk_addr[e] == rd_addr && lk_wr[e]) begin
        rd_hit_any = 1'b1;
        rd_ent     = ENT_W'(e);
      end
      if (lk_valid[e] && wr_nz && lk_addr[e] == wr_addr) begin
        wr_hit_any = 1'b1;
        wr_ent     = ENT_W'(e);
      end
    end
    last      = (idx_p1 == IDX_W'(DEPS_PER_TRANSACTION - 1));
    nz_total  = nz_cnt_p1 + CW'(rd_nz) + CW'(wr_nz);
    overflow  = nz_total > (CW'(LOCK_ENTRIES) - used_cnt);
    reject_id = rd_hit_any ? lk_owner[rd_ent] :
                wr_hit_any ? lk_owner[wr_ent] : {DATA_W{1'b1}};
  end

  // Insertion stage: the two lowest free entries take this slot's read and write addresses.
  always_comb begin
    f0    = '0;
    f1    = '0;
    f0_ok = 1'b0;
    f1_ok = 1'b0;
    for (int e = 0; e < LOCK_ENTRIES; e++) begin
      if (!lk_valid[e]) begin
        if (!f0_ok) begin
          f0    = ENT_W'(e);
          f0_ok = 1'b1;
        end else if (!f1_ok) begin
          f1    = ENT_W'(e);
          f1_ok = 1'b1;
        end
      end
    end
    wr_slot = rd_nz ? f1 : f0;
  end

  always_comb begin
    state_nxt       = state;
    filter_ready    = 1'b0;
    insertion_ready = 1'b0;
    case (state)
      S_IDLE:   if (transaction_valid) state_nxt = S_FILTER;
      S_FILTER: begin
        if (rd_hit_any || wr_hit_any) state_nxt = S_REJECT;
        else if (last) begin
          if (overflow) state_nxt = S_REJECT;
          else begin
            filter_ready = 1'b1;
            state_nxt    = S_INSERT;
          end
        end
      end
      S_INSERT: if (last) begin
        insertion_ready = 1'b1;
        state_nxt       = S_DONE;
      end
      S_DONE:   state_nxt = S_IDLE;
      S_REJECT: state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state                <= S_IDLE;
      idx_p1               <= '0;
      nz_cnt_p1            <= '0;
      used_cnt             <= '0;
      batch_cnt            <= '0;
      batch_full           <= 1'b0;
      transaction_accepted <= 1'b0;
      has_conflict         <= 1'b0;
      inserted_programID   <= '0;
      conflicting_id       <= '0;
      for (int e = 0; e < LOCK_ENTRIES; e++) lk_valid[e] <= 1'b0;
    end else begin
      state                <= state_nxt;
      transaction_accepted <= (state == S_DONE);
      has_conflict         <= (state == S_REJECT);
      case (state)
        S_IDLE: begin
          idx_p1    <= '0;
          nz_cnt_p1 <= '0;
        end
        S_FILTER: begin
          idx_p1    <= filter_ready ? '0 : idx_p1 + 1'b1;
          nz_cnt_p1 <= nz_total;
          if (state_nxt == S_REJECT) conflicting_id <= reject_id;
        end
        S_INSERT: begin
          idx_p1 <= insertion_ready ? '0 : idx_p1 + 1'b1;
          if (rd_nz) lk_valid[f0] <= 1'b1;
          if (wr_nz) lk_valid[wr_slot] <= 1'b1;
          used_cnt <= used_cnt + CW'(rd_nz) + CW'(wr_nz);
        end
        S_DONE: begin
          inserted_programID <= owner_id_p0;
          batch_cnt          <= batch_cnt + 1'b1;
          batch_full         <= (batch_cnt == BW'(MAX_TRANSACTIONS - 1));
        end
        default: ;
      endcase
      // Batch stage: a full batch releases every lock one cycle after its last accept.
      if (batch_full) begin
        for (int e = 0; e < LOCK_ENTRIES; e++) lk_valid[e] <= 1'b0;
        used_cnt   <= '0;
        batch_cnt  <= '0;
        batch_full <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (state == S_IDLE && transaction_valid) begin
      owner_id_p0 <= owner_programID;
      rd_vec_p0   <= read_dependencies;
      wr_vec_p0   <= write_dependencies;
    end
    if (state == S_INSERT) begin
      if (rd_nz) begin
        lk_addr[f0]  <= rd_addr;
        lk_wr[f0]    <= 1'b0;
        lk_owner[f0] <= owner_id_p0;
      end
      if (wr_nz) begin
        lk_addr[wr_slot]  <= wr_addr;
        lk_wr[wr_slot]    <= 1'b1;
        lk_owner[wr_slot] <= owner_id_p0;
      end
    end
  end
endmodule

// File: tb/tb_svm_scheduler_top.sv
// Bench for svm_scheduler_top: directed hazard/overflow/batch cases, then random transactions
// against a lock-table model kept as plain arrays.
module tb_svm_scheduler_top;
  localparam int MAXT = 8;
  localparam int DEPS = 16;
  localparam int LOCK = 16;
  localparam int VW   = DEPS * 64;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [63:0]   owner_programID = '0;
  logic [VW-1:0] read_dependencies = '0;
  logic [VW-1:0] write_dependencies = '0;
  logic          transaction_valid = 1'b0;
  logic          transaction_accepted, has_conflict;
  logic [63:0]   inserted_programID, conflicting_id;

  always #5 clk = ~clk;

  svm_scheduler_top #(.MAX_TRANSACTIONS(MAXT), .DEPS_PER_TRANSACTION(DEPS), .LOCK_ENTRIES(LOCK)) dut (
    .clk(clk), .rst_n(rst_n), .owner_programID(owner_programID),
    .read_dependencies(read_dependencies), .write_dependencies(write_dependencies),
    .transaction_valid(transaction_valid), .transaction_accepted(transaction_accepted),
    .inserted_programID(inserted_programID), .has_conflict(has_conflict),
    .conflicting_id(conflicting_id));

  int n_cmp = 0;
  int n_bad = 0;

  logic        m_valid [LOCK];
  logic [63:0] m_addr  [LOCK];
  logic        m_wr    [LOCK];
  logic [63:0] m_owner [LOCK];
  int          m_batch;
  logic [63:0] exp_ins = '0;
  logic [63:0] exp_conf = '0;
  bit          hold_chk = 1'b0;
  bit          mon_en = 1'b0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  function automatic logic [VW-1:0] put(input logic [VW-1:0] v, input int i, input logic [63:0] a);
    logic [VW-1:0] r;
    r = v;
    r[i*64 +: 64] = a;
    return r;
  endfunction

  task automatic model_clear();
    for (int e = 0; e < LOCK; e++) m_valid[e] = 1'b0;
    m_batch = 0;
  endtask

  // Decide accept/reject from the hazard rules, and commit an accepted transaction into the model.
  task automatic run_model(input logic [63:0] id, input logic [VW-1:0] rd, input logic [VW-1:0] wr,
                           output bit acc, output logic [63:0] cid);
    logic [63:0] a;
    int cnt, nfree;
    acc = 1'b1;
    cid = id;
    cnt = 0;
    for (int i = 0; i < DEPS; i++) begin
      for (int k = 0; k < 2; k++) begin
        a = (k == 1) ? wr[i*64 +: 64] : rd[i*64 +: 64];
        if (a != 0) begin
          cnt++;
          if (acc) begin
            for (int e = 0; e < LOCK; e++) begin
              if (m_valid[e] && m_addr[e] == a && (k == 1 || m_wr[e])) begin
                acc = 1'b0;
                cid = m_owner[e];
                break;
              end
            end
          end
        end
      end
    end
    if (acc) begin
      nfree = 0;
      for (int e = 0; e < LOCK; e++) if (!m_valid[e]) nfree++;
      if (cnt > nfree) begin
        acc = 1'b0;
        cid = '1;
      end
    end
    if (acc) begin
      for (int i = 0; i < DEPS; i++) begin
        for (int k = 0; k < 2; k++) begin
          a = (k == 1) ? wr[i*64 +: 64] : rd[i*64 +: 64];
          if (a != 0) begin
            for (int e = 0; e < LOCK; e++) begin
              if (!m_valid[e]) begin
                m_valid[e] = 1'b1;
                m_addr[e]  = a;
                m_wr[e]    = (k == 1);
                m_owner[e] = id;
                break;
              end
            end
          end
        end
      end
      m_batch++;
      if (m_batch == MAXT) model_clear();
    end
  endtask

  task automatic submit(input logic [63:0] id, input logic [VW-1:0] rd, input logic [VW-1:0] wr,
                        input bit use_lit, input bit lit_acc, input logic [63:0] lit_id);
    bit eacc;
    logic [63:0] eid;
    int cyc;
    run_model(id, rd, wr, eacc, eid);
    if (use_lit) begin
      check("model_accept", 64'(eacc), 64'(lit_acc));
      check("model_id", eid, lit_id);
    end
    @(posedge clk); #1;
    hold_chk           = 1'b0;
    owner_programID    = id;
    read_dependencies  = rd;
    write_dependencies = wr;
    transaction_valid  = 1'b1;
    @(posedge clk); #1;
    transaction_valid  = 1'b0;
    owner_programID    = ~id;
    read_dependencies  = rd ^ {(VW/32){$urandom}};
    write_dependencies = wr ^ {(VW/32){$urandom}};
    cyc = 0;
    while (cyc < 2 * DEPS + 10) begin
      @(negedge clk);
      if (transaction_accepted || has_conflict) break;
      if (eacc && cyc == 3) begin
        owner_programID   = id + 64'd1;
        transaction_valid = 1'b1;
      end
      if (cyc == 5) transaction_valid = 1'b0;
      cyc++;
    end
    transaction_valid = 1'b0;
    if (!(transaction_accepted || has_conflict)) begin
      n_cmp++;
      n_bad++;
      $display("FAIL timeout: id %h got no result within %0d cycles", id, cyc);
    end else begin
      check("accepted", 64'(transaction_accepted), 64'(eacc));
      check("has_conflict", 64'(has_conflict), 64'(!eacc));
      if (eacc) begin
        exp_ins = id;
        check("inserted_id", inserted_programID, id);
        check("accept_latency_ok", 64'(cyc <= 2 * DEPS + 3), 64'd1);
      end else begin
        exp_conf = eid;
        check("conflicting_id", conflicting_id, eid);
        check("reject_latency_ok", 64'(cyc <= DEPS + 2), 64'd1);
      end
    end
    @(posedge clk); #1;
    hold_chk = 1'b1;
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (transaction_accepted && has_conflict) check("pulse_exclusive", 64'd1, 64'd0);
      else n_cmp++;
      if (hold_chk) begin
        check("idle_accept_low", 64'(transaction_accepted), 64'd0);
        check("idle_conflict_low", 64'(has_conflict), 64'd0);
        check("held_inserted_id", inserted_programID, exp_ins);
        check("held_conflicting_id", conflicting_id, exp_conf);
      end
    end
  end

  initial begin
    logic [VW-1:0] z, v1, v2;
    logic [63:0] a;
    bit racc;
    logic [63:0] rid;
    z = '0;
    model_clear();
    repeat (2) @(negedge clk);
    check("rst_accepted", 64'(transaction_accepted), 64'd0);
    check("rst_conflict", 64'(has_conflict), 64'd0);
    check("rst_inserted_id", inserted_programID, 64'd0);
    check("rst_conflicting_id", conflicting_id, 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    mon_en = 1'b1;
    hold_chk = 1'b1;

    submit(64'd1, z, put(z, 2, 64'd5), 1, 1, 64'd1);
    submit(64'd2, put(z, 10, 64'd5), z, 1, 0, 64'd1);
    submit(64'd3, z, put(z, 12, 64'd10), 1, 1, 64'd3);
    submit(64'd4, z, put(z, 15, 64'd10), 1, 0, 64'd3);
    submit(64'd5, put(z, 0, 64'h8000), z, 1, 1, 64'd5);
    submit(64'd6, z, put(z, 0, 64'h8000), 1, 0, 64'd5);
    submit(64'd7, put(z, 4, 64'h8000), z, 1, 1, 64'd7);
    submit(64'd6, z, z, 1, 1, 64'd6);
    submit(64'hB, z, z, 1, 1, 64'hB);
    submit(64'h4D2, z, put(z, 0, 64'h800), 1, 1, 64'h4D2);
    submit(64'h10E1, z, put(z, 0, 64'h800), 1, 0, 64'h4D2);
    v1 = z;
    for (int i = 0; i < 12; i++) v1 = put(v1, i, 64'h2000 + 64'(i));
    submit(64'h40, v1, z, 1, 0, '1);
    v2 = z;
    for (int i = 0; i < 11; i++) v2 = put(v2, i, 64'h1000 + 64'(i));
    submit(64'h50, z, v2, 1, 1, 64'h50);
    submit(64'h10E1, z, put(z, 0, 64'h800), 1, 1, 64'h10E1);
    submit(64'h20, put(z, 3, 64'h99), put(z, 3, 64'h99), 1, 1, 64'h20);

    for (int t = 0; t < 40; t++) begin
      int mode;
      v1 = z;
      v2 = z;
      mode = int'($urandom_range(0, 5));
      if (mode != 0) begin
        for (int i = 0; i < DEPS; i++) begin
          a = 64'($urandom_range(1, 12)) | (($urandom_range(0, 3) == 0) ? 64'h8000_0000_0000_0000 : 64'd0);
          if ($urandom_range(0, (mode == 1) ? 1 : 7) == 0) v1 = put(v1, i, a);
          a = 64'($urandom_range(1, 12));
          if ($urandom_range(0, (mode == 1) ? 1 : 9) == 0) v2 = put(v2, i, a);
        end
      end
      submit({$urandom, $urandom}, v1, v2, 0, 0, '0);
    end

    @(posedge clk); #1;
    hold_chk           = 1'b0;
    owner_programID    = 64'h99;
    read_dependencies  = z;
    write_dependencies = put(z, 0, 64'h5555);
    transaction_valid  = 1'b1;
    @(posedge clk); #1;
    transaction_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    check("midrst_accepted", 64'(transaction_accepted), 64'd0);
    check("midrst_conflict", 64'(has_conflict), 64'd0);
    check("midrst_inserted_id", inserted_programID, 64'd0);
    check("midrst_conflicting_id", conflicting_id, 64'd0);
    model_clear();
    exp_ins  = '0;
    exp_conf = '0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    hold_chk = 1'b1;
    submit(64'h9A, put(z, 1, 64'h5555), z, 1, 1, 64'h9A);
    run_model(64'h9B, z, put(z, 0, 64'h5555), racc, rid);
    check("model_post_reset_war", rid, 64'h9A);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
